// File: rtl/seven_seg_capture_pkg.sv
// rtl/seven_seg_capture_pkg.sv - shared segment patterns, anode slots and capture FSM states
//
// Purpose: constants shared between the seven-segment capture block and the
// display-controller bench.
//   SEG_0..SEG_9 : active-high segment patterns, bit [0]=a .. [6]=g
//   SLOT_*       : anode bit index for each display digit
//   state_e      : capture FSM states
package seven_seg_capture_pkg;

    localparam logic [0:6] SEG_0 = 7'b1111110;
    localparam logic [0:6] SEG_1 = 7'b0110000;
    localparam logic [0:6] SEG_2 = 7'b1101101;
    localparam logic [0:6] SEG_3 = 7'b1111001;
    localparam logic [0:6] SEG_4 = 7'b0110011;
    localparam logic [0:6] SEG_5 = 7'b1011011;
    localparam logic [0:6] SEG_6 = 7'b1011111;
    localparam logic [0:6] SEG_7 = 7'b1110000;
    localparam logic [0:6] SEG_8 = 7'b1111111;
    localparam logic [0:6] SEG_9 = 7'b1111011;

    localparam logic [1:0] SLOT_MIN_LSD = 2'd0;
    localparam logic [1:0] SLOT_MIN_MSD = 2'd1;
    localparam logic [1:0] SLOT_HR_LSD  = 2'd2;
    localparam logic [1:0] SLOT_HR_MSD  = 2'd3;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        CHECK = 2'd1,
        PUB   = 2'd2
    } state_e;

endpackage

// File: rtl/seven_seg_capture_seg_to_digit.sv
// rtl/seven_seg_capture_seg_to_digit.sv - combinational seven-segment to BCD decoder
//
// Purpose: map a segment pattern back to its decimal digit.
// Ports:
//   seg     in  [0:6] segment pattern, [0]=a .. [6]=g
//   bcd     out [0:3] decoded digit 0..9 (0 when illegal)
//   illegal out 1     pattern is not one of the ten digit shapes (blank included)
module seg_to_digit
    import seven_seg_capture_pkg::*;
(
    input  logic [0:6] seg,
    output logic [0:3] bcd,
    output logic       illegal
);

    always_comb begin
        bcd     = 4'd0;
        illegal = 1'b0;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - recover HH:MM from a multiplexed 4-digit seven-segment scan
//
// Purpose: sample anode/segment lines, debounce each digit, decode it to BCD,
// and after a complete scan publish binary minutes and hours.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   anode        in   [0:3] one-hot digit select ([0]=min LSD .. [3]=hr MSD)
//   segment      in   [0:6] active-high segments, [0]=a .. [6]=g
//   min          out  [0:5] last published minutes 0..59
//   hr           out  [0:5] last published hours 0..23
//   frame_valid  out  pulse, min/hr carry a freshly published frame
//   digit_err    out  pulse, an accepted pattern was not a digit
//   range_err    out  pulse, a complete frame had min>59 or hr>23
//   stale        out  level, no frame published for TIMEOUT_CYCLES cycles
module seven_seg_capture
    import seven_seg_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TMO_W          = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:3] anode,
    input  logic [0:6] segment,
    output logic [0:5] min,
    output logic [0:5] hr,
    output logic       frame_valid,
    output logic       digit_err,
    output logic       range_err,
    output logic       stale
);

    // The settle counter saturates at SETTLE_CYCLES-1, so it only needs to hold that value.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic [0:3]       anode_q;
    logic [0:6]       seg_q;
    logic [10:0]      prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       slot_q [4];
    logic [3:0]       slot_d [4];
    state_e           state_q, state_d;
    logic [5:0]       min_q, min_d, hr_q, hr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic       same, onehot, accept, dig_illegal, in_range;
    logic [0:3] dig_bcd;
    logic [1:0] slot_idx;
    logic [6:0] mins_w, hrs_w;

    seg_to_digit u_seg_to_digit (
        .seg     (seg_q),
        .bcd     (dig_bcd),
        .illegal (dig_illegal)
    );

    assign same   = ({anode_q, seg_q} == prev_q);
    assign onehot = $onehot(anode_q);

    always_comb begin
        cnt_d = '0;
        if (same && onehot) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Fire only on the transition into the saturated count; a pattern that was
    // already saturated last cycle has been accepted and must not fire again.
    assign accept = onehot && (cnt_d == CNT_MAX) && !(same && (cnt_q == CNT_MAX));

    always_comb begin
        slot_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (anode_q[i]) begin
                slot_idx = 2'(i);
            end
        end
    end

    assign mins_w   = 7'(slot_q[SLOT_MIN_MSD]) * 7'd10 + 7'(slot_q[SLOT_MIN_LSD]);
    assign hrs_w    = 7'(slot_q[SLOT_HR_MSD]) * 7'd10 + 7'(slot_q[SLOT_HR_LSD]);
    assign in_range = (mins_w <= 7'd59) && (hrs_w <= 7'd23);

    // min/hr and the timeout counter are updated on the edge into PUB so the
    // new values are already visible in the cycle frame_valid is high.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        slot_d  = slot_q;
        min_d   = min_q;
        hr_d    = hr_q;
        case (state_q)
            SCAN: begin
                if (accept) begin
                    if (dig_illegal) begin
                        mask_d = '0;
                    end else begin
                        slot_d[slot_idx] = dig_bcd;
                        mask_d[slot_idx] = 1'b1;
                    end
                end
                if (mask_d == 4'b1111) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (in_range) begin
                    state_d = PUB;
                    min_d   = mins_w[5:0];
                    hr_d    = hrs_w[5:0];
                end else begin
                    state_d = SCAN;
                    mask_d  = '0;
                end
            end
            PUB: begin
                state_d = SCAN;
                mask_d  = '0;
            end
            default: begin
                state_d = SCAN;
                mask_d  = '0;
            end
        endcase
    end

    always_comb begin
        if (state_d == PUB) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            anode_q <= '0;
            seg_q   <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            state_q <= SCAN;
            min_q   <= '0;
            hr_q    <= '0;
            tmo_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            anode_q <= anode;
            seg_q   <= segment;
            prev_q  <= {anode_q, seg_q};
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            state_q <= state_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            tmo_q   <= tmo_d;
            slot_q  <= slot_d;
        end
    end

    // Pulses are masked while reset is high so a frame in flight cannot leak out.
    assign frame_valid = !reset && (state_q == PUB);
    assign range_err   = !reset && (state_q == CHECK) && !in_range;
    assign digit_err   = !reset && (state_q == SCAN) && accept && dig_illegal;
    assign stale       = (tmo_q == TMO_MAX);
    assign min         = min_q;
    assign hr          = hr_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - self-checking bench for seven_seg_capture
module tb_seven_seg_capture;

    localparam int SETTLE = 4;
    localparam int TMO    = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:3] anode;
    logic [0:6] segment;
    logic [0:5] min_o, hr_o;
    logic       fv, de, re, st;

    always #5 clk = ~clk;

    seven_seg_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO),
        .TMO_W          (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .anode       (anode),
        .segment     (segment),
        .min         (min_o),
        .hr          (hr_o),
        .frame_valid (fv),
        .digit_err   (de),
        .range_err   (re),
        .stale       (st)
    );

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    int checks = 0;
    int errors = 0;

    // reference model state
    int          n = 0;
    logic [10:0] m_prev;
    int          m_run;
    int          m_dig [4];
    bit          m_have [4];
    int          fv_at, re_at, busy_until, last_ref;
    int          pend_min, pend_hr, m_min, m_hr;
    int          cnt_fv = 0, cnt_de = 0, cnt_re = 0, last_fv_n = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev     = '0;
        m_run      = 1;
        fv_at      = -1;
        re_at      = -1;
        busy_until = -1;
        last_ref   = n;
        m_min      = 0;
        m_hr       = 0;
        for (int i = 0; i < 4; i++) m_have[i] = 0;
    endtask

    task automatic step(input logic [0:3] an, input logic [0:6] sg);
        bit e_fv, e_de, e_re, e_st, acc;
        int slot, d, mins, hrs;
        anode   = an;
        segment = sg;
        @(posedge clk);
        n++;
        e_fv = 0; e_de = 0; e_re = 0; e_st = 0;
        if (reset) begin
            model_reset();
        end else begin
            if ({an, sg} == m_prev) m_run++;
            else m_run = 1;
            m_prev = {an, sg};
            acc  = ($countones(an) == 1) && (m_run == SETTLE);
            e_fv = (fv_at == n);
            e_re = (re_at == n);
            if (e_fv) begin
                m_min    = pend_min;
                m_hr     = pend_hr;
                last_ref = n;
            end
            if (acc && n > busy_until) begin
                slot = 0;
                for (int i = 0; i < 4; i++) if (an[i]) slot = i;
                d = -1;
                for (int k = 0; k < 10; k++) if (sg == seg_tab[k]) d = k;
                if (d < 0) begin
                    e_de = 1;
                    for (int i = 0; i < 4; i++) m_have[i] = 0;
                end else begin
                    m_dig[slot]  = d;
                    m_have[slot] = 1;
                    if (m_have[0] && m_have[1] && m_have[2] && m_have[3]) begin
                        mins = m_dig[1] * 10 + m_dig[0];
                        hrs  = m_dig[3] * 10 + m_dig[2];
                        if (mins <= 59 && hrs <= 23) begin
                            fv_at      = n + 2;
                            busy_until = n + 2;
                            pend_min   = mins;
                            pend_hr    = hrs;
                        end else begin
                            re_at      = n + 1;
                            busy_until = n + 1;
                        end
                        for (int i = 0; i < 4; i++) m_have[i] = 0;
                    end
                end
            end
            e_st = (n - last_ref) >= TMO;
        end
        @(negedge clk);
        if (fv) begin cnt_fv++; last_fv_n = n; end
        if (de) cnt_de++;
        if (re) cnt_re++;
        chk($sformatf("cycle%0d outputs{fv,de,re,stale,min,hr}", n),
            32'({fv, de, re, st, min_o, hr_o}),
            32'({e_fv, e_de, e_re, e_st, 6'(m_min), 6'(m_hr)}));
    endtask

    task automatic drive_frame(input int hm, input int hl, input int mm, input int ml,
                               input int hold, input bit glitch, input bit bad, output int acc_n);
        int dg [4];
        logic [0:3] an;
        dg[0] = ml; dg[1] = mm; dg[2] = hl; dg[3] = hm;
        acc_n = -1;
        for (int s = 0; s < 4; s++) begin
            if (glitch) step((n % 2 == 1) ? 4'b0000 : 4'b0101, 7'($urandom));
            if (bad && s == 3) begin
                for (int h = 0; h < hold; h++) step(4'b1000, 7'b1000001);
            end else begin
                an = 4'b1000 >> s;
                for (int h = 0; h < hold; h++) begin
                    step(an, seg_tab[dg[s]]);
                    if (h == SETTLE - 1) acc_n = n;
                end
            end
        end
        for (int t = 0; t < 3; t++) step(4'b0000, 7'b0000000);
    endtask

    typedef struct {
        int hm, hl, mm, ml, hold;
        bit glitch, bad;
        int e_fv, e_de, e_re, e_hr, e_min;
    } row_t;

    row_t rows [9];

    initial begin
        int b_fv, b_de, b_re, acc_n;
        rows[0] = '{1, 2, 3, 4, 8, 0, 0, 1, 0, 0, 12, 34};
        rows[1] = '{0, 9, 4, 5, 3, 0, 0, 0, 0, 0, 12, 34};
        rows[2] = '{0, 9, 4, 5, 4, 0, 0, 1, 0, 0,  9, 45};
        rows[3] = '{1, 2, 3, 4, 6, 0, 1, 0, 1, 0,  9, 45};
        rows[4] = '{1, 2, 3, 4, 8, 0, 0, 1, 0, 0, 12, 34};
        rows[5] = '{2, 7, 7, 5, 8, 0, 0, 0, 0, 1, 12, 34};
        rows[6] = '{2, 3, 5, 9, 5, 1, 0, 1, 0, 0, 23, 59};
        rows[7] = '{2, 4, 0, 0, 6, 0, 0, 0, 0, 1, 23, 59};
        rows[8] = '{1, 9, 6, 0, 6, 1, 0, 0, 0, 1, 23, 59};

        reset   = 1'b1;
        anode   = '0;
        segment = '0;
        step(4'b0000, 7'b0);
        step(4'b0000, 7'b0);
        reset = 1'b0;
        step(4'b0000, 7'b0);

        for (int r = 0; r < 9; r++) begin
            b_fv = cnt_fv; b_de = cnt_de; b_re = cnt_re;
            drive_frame(rows[r].hm, rows[r].hl, rows[r].mm, rows[r].ml,
                        rows[r].hold, rows[r].glitch, rows[r].bad, acc_n);
            chk($sformatf("row%0d pulse counts{fv,de,re}", r),
                {8'(cnt_fv - b_fv), 8'(cnt_de - b_de), 8'(cnt_re - b_re)},
                {8'(rows[r].e_fv), 8'(rows[r].e_de), 8'(rows[r].e_re)});
            chk($sformatf("row%0d hr:min", r), 32'({hr_o, min_o}),
                32'({6'(rows[r].e_hr), 6'(rows[r].e_min)}));
            if (rows[r].e_fv == 1)
                chk($sformatf("row%0d frame latency", r), 32'(last_fv_n - acc_n), 32'd2);
        end

        // scan stops: stale must rise, then a good frame clears it
        for (int i = 0; i < TMO + 6; i++) step(4'b0000, 7'b0);
        chk("stale after idle", 32'(st), 32'd1);
        b_fv = cnt_fv;
        drive_frame(2, 3, 5, 9, 5, 0, 0, acc_n);
        chk("stale resume frame count", 32'(cnt_fv - b_fv), 32'd1);
        chk("stale cleared", 32'(st), 32'd0);
        chk("stale resume hr:min", 32'({hr_o, min_o}), 32'({6'd23, 6'd59}));

        // reset in the middle of a partial 08:15 frame
        for (int h = 0; h < 6; h++) step(4'b1000, seg_tab[5]);
        for (int h = 0; h < 6; h++) step(4'b0100, seg_tab[1]);
        reset = 1'b1;
        #1;
        chk("pulses in reset cycle", 32'({fv, de, re}), 32'd0);
        step(4'b0010, seg_tab[8]);
        step(4'b0010, seg_tab[8]);
        reset = 1'b0;
        step(4'b0010, seg_tab[8]);
        chk("outputs after reset", 32'({fv, de, re, st, min_o, hr_o}), 32'd0);
        b_fv = cnt_fv;
        drive_frame(0, 8, 1, 5, 6, 0, 0, acc_n);
        chk("post-reset frame count", 32'(cnt_fv - b_fv), 32'd1);
        chk("post-reset hr:min", 32'({hr_o, min_o}), 32'({6'd8, 6'd15}));

        // randomized scans, checked cycle by cycle against the model
        for (int r = 0; r < 25; r++) begin
            drive_frame($urandom_range(0, 2), $urandom_range(0, 9), $urandom_range(0, 7),
                        $urandom_range(0, 9), $urandom_range(3, 7),
                        bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), acc_n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
